// File: rtl/dpi_run_ctrl.sv
// Run-sequencing controller between the DPI-C harness and the accelerator datapath.
// One command outstanding, one registered response per accepted command, free-running cycle counter.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   RESET | post-reset settle, RESET_CYC cycles, all commands blocked
//   LOAD  | datapath loading; waits one cycle, then for dut_busy low
//   READY | loaded, waiting for START
//   RUN   | datapath running; run_cycles counts, optional timeout
//   POLL  | one-cycle status snapshot inside a run, returns to RUN
//   STOP  | idle; needs LOAD before the next run
//   ERROR | datapath error or run timeout; needs CLR
module dpi_run_ctrl #(
    parameter int CYCLE_W   = 64,
    parameter int TO_W      = 32,
    parameter int RESET_CYC = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [2:0]         cmd_op,
    input  logic [CYCLE_W-1:0] cmd_arg,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_ok,
    output logic [2:0]         rsp_state,
    output logic [CYCLE_W-1:0] rsp_data,
    output logic               dut_load,
    output logic               dut_start,
    output logic               dut_abort,
    input  logic               dut_busy,
    input  logic               dut_done,
    input  logic               dut_err,
    output logic [CYCLE_W-1:0] cycle,
    output logic [2:0]         state
);

    localparam int RCW = (RESET_CYC > 1) ? $clog2(RESET_CYC) : 1;

    typedef enum logic [2:0] {
        S_RESET = 3'd0,
        S_LOAD  = 3'd1,
        S_READY = 3'd2,
        S_RUN   = 3'd3,
        S_POLL  = 3'd4,
        S_STOP  = 3'd5,
        S_ERROR = 3'd6
    } state_t;

    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_LOAD    = 3'd1;
    localparam logic [2:0] OP_START   = 3'd2;
    localparam logic [2:0] OP_POLL    = 3'd3;
    localparam logic [2:0] OP_STOP    = 3'd4;
    localparam logic [2:0] OP_CLR     = 3'd5;
    localparam logic [2:0] OP_CLK_SET = 3'd6;
    localparam logic [2:0] OP_CLK_ADD = 3'd7;

    state_t             state_q, state_d;
    logic [RCW-1:0]     rst_cnt_q, rst_cnt_d;
    logic               load_wait_q, load_wait_d;
    logic [CYCLE_W-1:0] cycle_q, cycle_d;
    logic [CYCLE_W-1:0] run_cycles_q, run_cycles_d;
    logic [TO_W-1:0]    timeout_q, timeout_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_ok_q, rsp_ok_d;
    logic [2:0]         rsp_state_q, rsp_state_d;
    logic [CYCLE_W-1:0] rsp_data_q, rsp_data_d;
    logic               dut_load_q, dut_load_d;
    logic               dut_start_q, dut_start_d;
    logic               dut_abort_q, dut_abort_d;

    logic cmd_fire, cmd_legal, in_run, run_evt, timer_hit;
    logic rsp_set, rsp_ok_n, rsp_poll;

    always_comb begin
        state_d      = state_q;
        rst_cnt_d    = rst_cnt_q;
        load_wait_d  = load_wait_q;
        cycle_d      = cycle_q + CYCLE_W'(1);
        run_cycles_d = run_cycles_q;
        timeout_d    = timeout_q;
        rsp_valid_d  = rsp_valid_q && !rsp_ready;
        rsp_ok_d     = rsp_ok_q;
        rsp_state_d  = rsp_state_q;
        rsp_data_d   = rsp_data_q;
        dut_load_d   = 1'b0;
        dut_start_d  = 1'b0;
        dut_abort_d  = 1'b0;
        cmd_ready_d  = 1'b0;
        run_evt      = 1'b0;
        timer_hit    = 1'b0;
        rsp_set      = 1'b0;
        rsp_ok_n     = 1'b0;
        rsp_poll     = 1'b0;

        cmd_fire = cmd_valid && cmd_ready_q;
        in_run   = (state_q == S_RUN) || (state_q == S_POLL);

        case (cmd_op)
            OP_LOAD:  cmd_legal = (state_q == S_STOP) || (state_q == S_READY);
            OP_START: cmd_legal = (state_q == S_READY);
            OP_POLL:  cmd_legal = in_run || (state_q == S_STOP) || (state_q == S_ERROR);
            OP_STOP:  cmd_legal = in_run || (state_q == S_STOP) || (state_q == S_READY);
            OP_CLR:   cmd_legal = (state_q == S_STOP) || (state_q == S_ERROR);
            default:  cmd_legal = 1'b1;
        endcase

        case (state_q)
            S_RESET: begin
                if (rst_cnt_q == '0) state_d = S_STOP;
                else                 rst_cnt_d = rst_cnt_q - RCW'(1);
            end
            S_LOAD: begin
                load_wait_d = 1'b0;
                if (dut_err) begin
                    state_d  = S_ERROR;
                    rsp_set  = 1'b1;
                    rsp_ok_n = 1'b0;
                end else if (!load_wait_q && !dut_busy) begin
                    state_d  = S_READY;
                    rsp_set  = 1'b1;
                    rsp_ok_n = 1'b1;
                end
            end
            S_RUN, S_POLL: begin
                if (run_cycles_q != '1) run_cycles_d = run_cycles_q + CYCLE_W'(1);
                if (timeout_q != '0) begin
                    timeout_d = timeout_q - TO_W'(1);
                    timer_hit = (timeout_q == TO_W'(1));
                end
                state_d = S_RUN;
                run_evt = 1'b1;
                if (dut_err)        state_d = S_ERROR;
                else if (dut_done)  state_d = S_STOP;
                else if (timer_hit) state_d = S_ERROR;
                else                run_evt = 1'b0;
            end
            default: ;
        endcase

        // A datapath event in the same cycle preempts any run-state change the command asked for.
        if (cmd_fire) begin
            rsp_set  = 1'b1;
            rsp_ok_n = cmd_legal;
            rsp_poll = (cmd_op == OP_POLL);
            if (cmd_legal) begin
                case (cmd_op)
                    OP_LOAD: begin
                        state_d     = S_LOAD;
                        dut_load_d  = 1'b1;
                        load_wait_d = 1'b1;
                        rsp_set     = 1'b0;
                    end
                    OP_START: begin
                        state_d      = S_RUN;
                        dut_start_d  = 1'b1;
                        run_cycles_d = '0;
                        timeout_d    = cmd_arg[TO_W-1:0];
                    end
                    OP_POLL: begin
                        if (in_run) begin
                            if (run_evt) rsp_ok_n = 1'b0;
                            else         state_d  = S_POLL;
                        end
                    end
                    OP_STOP: begin
                        if (in_run) begin
                            if (run_evt) begin
                                rsp_ok_n = 1'b0;
                            end else begin
                                state_d     = S_STOP;
                                dut_abort_d = 1'b1;
                            end
                        end
                    end
                    OP_CLR: begin
                        state_d      = S_STOP;
                        run_cycles_d = '0;
                    end
                    OP_CLK_SET: cycle_d = cmd_arg;
                    OP_CLK_ADD: cycle_d = cycle_q + cmd_arg;
                    default: ;
                endcase
            end
        end

        if (rsp_set) begin
            rsp_valid_d = 1'b1;
            rsp_ok_d    = rsp_ok_n;
            rsp_state_d = state_d;
            rsp_data_d  = rsp_poll ? run_cycles_d : cycle_d;
        end

        cmd_ready_d = !rsp_valid_d && (state_d != S_RESET) && (state_d != S_LOAD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_RESET;
            rst_cnt_q    <= RCW'(RESET_CYC - 1);
            load_wait_q  <= 1'b0;
            cycle_q      <= '0;
            run_cycles_q <= '0;
            timeout_q    <= '0;
            cmd_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_ok_q     <= 1'b0;
            rsp_state_q  <= '0;
            rsp_data_q   <= '0;
            dut_load_q   <= 1'b0;
            dut_start_q  <= 1'b0;
            dut_abort_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            rst_cnt_q    <= rst_cnt_d;
            load_wait_q  <= load_wait_d;
            cycle_q      <= cycle_d;
            run_cycles_q <= run_cycles_d;
            timeout_q    <= timeout_d;
            cmd_ready_q  <= cmd_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_ok_q     <= rsp_ok_d;
            rsp_state_q  <= rsp_state_d;
            rsp_data_q   <= rsp_data_d;
            dut_load_q   <= dut_load_d;
            dut_start_q  <= dut_start_d;
            dut_abort_q  <= dut_abort_d;
        end
    end

    assign state     = state_q;
    assign cycle     = cycle_q;
    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_ok    = rsp_ok_q;
    assign rsp_state = rsp_state_q;
    assign rsp_data  = rsp_data_q;
    assign dut_load  = dut_load_q;
    assign dut_start = dut_start_q;
    assign dut_abort = dut_abort_q;

endmodule

// File: tb/tb_dpi_run_ctrl.sv
// Bench for dpi_run_ctrl: directed scenarios followed by a random command/event soak,
// every cycle compared against a table-driven behavioural model of the controller.
module tb_dpi_run_ctrl;

    localparam int RESET_CYC = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [2:0]  cmd_op = 3'd0;
    logic [63:0] cmd_arg = 64'd0;
    logic        rsp_ready = 1'b1;
    logic        dut_busy = 1'b0;
    logic        dut_done = 1'b0;
    logic        dut_err = 1'b0;
    logic        cmd_ready, rsp_valid, rsp_ok, dut_load, dut_start, dut_abort;
    logic [2:0]  rsp_state, state;
    logic [63:0] rsp_data, cycle;

    dpi_run_ctrl #(.CYCLE_W(64), .TO_W(32), .RESET_CYC(RESET_CYC)) u_dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_ok(rsp_ok),
        .rsp_state(rsp_state), .rsp_data(rsp_data),
        .dut_load(dut_load), .dut_start(dut_start), .dut_abort(dut_abort),
        .dut_busy(dut_busy), .dut_done(dut_done), .dut_err(dut_err),
        .cycle(cycle), .state(state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Which states (bit index = state code) accept each opcode.
    bit [6:0] legal_tbl [8] = '{7'h7F, 7'b0100100, 7'b0000100, 7'b1111000,
                                7'b0111100, 7'b1100000, 7'h7F, 7'h7F};

    int          m_state = 0;
    int          m_rst_left = 0;
    bit          m_load_first = 0;
    logic [63:0] m_cycle = '0;
    logic [63:0] m_run = '0;
    logic [31:0] m_to = '0;
    bit          m_cmd_ready = 0, m_rsp_valid = 0, m_rsp_ok = 0;
    int          m_rsp_state = 0;
    logic [63:0] m_rsp_data = '0;
    bit          m_load = 0, m_start = 0, m_abort = 0;

    task automatic model_step();
        bit fire, evt, tmr, rsp_now, rok, poll_sel, running;
        int nxt;
        logic [63:0] ncyc;
        if (rst) begin
            m_state = 0; m_rst_left = RESET_CYC; m_load_first = 0;
            m_cycle = '0; m_run = '0; m_to = '0;
            m_cmd_ready = 0; m_rsp_valid = 0; m_rsp_ok = 0; m_rsp_state = 0; m_rsp_data = '0;
            m_load = 0; m_start = 0; m_abort = 0;
        end else begin
            fire = cmd_valid && m_cmd_ready;
            running = (m_state == 3) || (m_state == 4);
            nxt = m_state; ncyc = m_cycle + 64'd1;
            m_load = 0; m_start = 0; m_abort = 0;
            evt = 0; rsp_now = 0; rok = 0; poll_sel = 0;
            if (m_rsp_valid && rsp_ready) m_rsp_valid = 0;
            if (m_state == 0) begin
                m_rst_left--;
                if (m_rst_left == 0) nxt = 5;
            end else if (m_state == 1) begin
                if (dut_err) begin nxt = 6; rsp_now = 1; rok = 0; end
                else if (!m_load_first && !dut_busy) begin nxt = 2; rsp_now = 1; rok = 1; end
                m_load_first = 0;
            end else if (running) begin
                if (m_run != '1) m_run++;
                tmr = (m_to == 32'd1);
                if (m_to != 0) m_to--;
                nxt = 3; evt = 1;
                if (dut_err) nxt = 6;
                else if (dut_done) nxt = 5;
                else if (tmr) nxt = 6;
                else evt = 0;
            end
            if (fire) begin
                rsp_now = 1; poll_sel = (cmd_op == 3'd3);
                rok = legal_tbl[cmd_op][m_state];
                if (rok) begin
                    case (cmd_op)
                        3'd1: begin nxt = 1; m_load = 1; m_load_first = 1; rsp_now = 0; end
                        3'd2: begin nxt = 3; m_start = 1; m_run = '0; m_to = cmd_arg[31:0]; end
                        3'd3: if (running) begin if (evt) rok = 0; else nxt = 4; end
                        3'd4: if (running) begin
                                  if (evt) rok = 0; else begin nxt = 5; m_abort = 1; end
                              end
                        3'd5: begin nxt = 5; m_run = '0; end
                        3'd6: ncyc = cmd_arg;
                        3'd7: ncyc = m_cycle + cmd_arg;
                        default: ;
                    endcase
                end
            end
            m_state = nxt;
            m_cycle = ncyc;
            if (rsp_now) begin
                m_rsp_valid = 1; m_rsp_ok = rok; m_rsp_state = nxt;
                m_rsp_data = poll_sel ? m_run : m_cycle;
            end
            m_cmd_ready = !m_rsp_valid && (nxt != 0) && (nxt != 1);
        end
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [2:0] ms, mrs;
        ms = 3'(m_state);
        mrs = 3'(m_rsp_state);
        chk("ctrl", {state, cmd_ready, rsp_valid, dut_load, dut_start, dut_abort},
            {ms, m_cmd_ready, m_rsp_valid, m_load, m_start, m_abort});
        chk("cycle", cycle, m_cycle);
        chk("rsp", {rsp_ok, rsp_state, rsp_data}, {m_rsp_ok, mrs, m_rsp_data});
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic send(input logic [2:0] op, input logic [63:0] arg);
        int n = 0;
        while (!m_cmd_ready && n < 100) begin tick(); n++; end
        chk("send_ready", cmd_ready, 1'b1);
        cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
        tick();
        cmd_valid = 1'b0; cmd_op = 3'd0; cmd_arg = 64'd0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        int n = 0;
        while (state !== s && n < budget) begin tick(); n++; end
        chk(tag, state, s);
    endtask

    task automatic wait_rsp(input string tag);
        int n = 0;
        while (rsp_valid !== 1'b1 && n < 60) begin tick(); n++; end
        chk(tag, rsp_valid, 1'b1);
    endtask

    task automatic do_load();
        send(3'd1, 64'd0);
        wait_state(3'd2, 30, "load_ready");
    endtask

    initial begin
        int n;
        rst = 1'b1;
        tick(); tick();
        chk("rst_out", {state, cmd_ready, rsp_valid, rsp_ok, dut_load, dut_start, dut_abort}, 9'd0);
        chk("rst_data", {cycle, rsp_data, rsp_state}, 131'd0);

        rst = 1'b0;
        n = 0;
        while (state === 3'd0 && n < 20) begin tick(); n++; end
        chk("reset_len", n, 4);
        chk("reset_exit", {state, cmd_ready}, {3'd5, 1'b1});

        send(3'd1, 64'd0);
        chk("load_entry", {state, dut_load}, {3'd1, 1'b1});
        dut_busy = 1'b1;
        repeat (10) tick();
        dut_busy = 1'b0;
        wait_rsp("load_rsp_valid");
        chk("load_rsp", {rsp_ok, rsp_state}, {1'b1, 3'd2});

        send(3'd2, 64'd100);
        chk("start_entry", {state, dut_start}, {3'd3, 1'b1});
        repeat (15) tick();
        send(3'd3, 64'd0);
        chk("poll_rsp", {rsp_ok, rsp_state, rsp_data}, {1'b1, 3'd4, 64'd16});
        repeat (20) tick();
        dut_done = 1'b1; tick(); dut_done = 1'b0;
        chk("done_stop", {state, dut_abort}, {3'd5, 1'b0});

        do_load();
        send(3'd2, 64'd20);
        n = 0;
        while (state === 3'd3 && n < 100) begin tick(); n++; end
        chk("timeout_len", n, 20);
        chk("timeout_err", state, 3'd6);
        send(3'd5, 64'd0);
        chk("clr_rsp", {rsp_ok, rsp_state}, {1'b1, 3'd5});
        send(3'd2, 64'd5);
        chk("start_in_stop", {rsp_ok, rsp_state}, {1'b0, 3'd5});

        send(3'd6, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("clk_set", cycle, 64'hFFFF_FFFF_FFFF_FFFE);
        repeat (3) tick();
        chk("clk_wrap", cycle, 64'd1);
        send(3'd7, 64'd5);
        chk("clk_add", {cycle, rsp_data}, {64'd6, 64'd6});

        do_load();
        send(3'd2, 64'd0);
        repeat (3) tick();
        dut_done = 1'b1; dut_err = 1'b1; tick(); dut_done = 1'b0; dut_err = 1'b0;
        chk("err_over_done", state, 3'd6);

        send(3'd5, 64'd0);
        do_load();
        send(3'd2, 64'd0);
        repeat (5) tick();
        rst = 1'b1; tick();
        chk("rst_in_run", {state, dut_abort, rsp_valid, cycle}, 69'd0);
        rst = 1'b0;
        wait_state(3'd5, 20, "rst_recover");

        for (int i = 0; i < 3000; i++) begin
            cmd_valid = ($urandom_range(0, 2) == 0);
            cmd_op    = 3'($urandom_range(0, 7));
            if (cmd_op == 3'd2) cmd_arg = 64'($urandom_range(0, 30));
            else                cmd_arg = {$urandom, $urandom};
            rsp_ready = ($urandom_range(0, 3) != 0);
            dut_busy  = ($urandom_range(0, 1) == 0);
            dut_done  = ($urandom_range(0, 29) == 0);
            dut_err   = ($urandom_range(0, 79) == 0);
            rst       = ($urandom_range(0, 599) == 0);
            tick();
        end
        cmd_valid = 1'b0; rst = 1'b0; dut_done = 1'b0; dut_err = 1'b0; dut_busy = 1'b0;
        rsp_ready = 1'b1;
        repeat (5) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
